// File: rtl/fft_result_streamer.sv
`default_nettype none
// =============================================================================
// fft_result_streamer: streams one frame of FFT results from a 1-cycle-latency
// result RAM onto an AXI-Stream master. Macro FFT_BITREV_READ_EN: bit-reversed reads.
// Revision: 1.0
// =============================================================================
module fft_result_streamer #(
  parameter int NUM_POINTS     = 8,
  parameter int SIZE_OF_SIGNAL = 50,
  parameter int ADDR_W         = $clog2(NUM_POINTS)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      mem_en_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic [SIZE_OF_SIGNAL-1:0] mem_data_i,
  output logic                      ms_tvalid,
  input  logic                      ms_tready,
  output logic                      ms_tlast,
  output logic [SIZE_OF_SIGNAL-1:0] signal_o,
  output logic                      done_o
);

  localparam int              CW       = ADDR_W + 1;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(NUM_POINTS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(NUM_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t                    state_q;
  logic [CW-1:0]             rd_cnt_q;
  logic [CW-1:0]             beat_cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      inflight_q;
  logic [1:0]                fifo_cnt_q;
  logic [1:0]                fifo_cnt_d;
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [SIZE_OF_SIGNAL-1:0] fifo_q [2];

  logic [1:0]                occupancy;
  logic                      rd_issue;
  logic                      tvalid;
  logic                      handshake;
  logic                      last_beat;
  logic [ADDR_W-1:0]         rd_addr;

  // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy = fifo_cnt_q + {1'b0, inflight_q};
  assign rd_issue  = (state_q == STREAM) && (rd_cnt_q != CNT_FULL) && (occupancy < 2'd2);
  assign tvalid    = (occupancy != 2'd0);
  assign handshake = tvalid && ms_tready;
  assign last_beat = (beat_cnt_q == CNT_LAST);

`ifdef FFT_BITREV_READ_EN
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      rd_addr[i] = rd_cnt_q[ADDR_W-1-i];
    end
  end
`else
  assign rd_addr = rd_cnt_q[ADDR_W-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + CNT_ONE;
      end
      if (handshake && (beat_cnt_q != CNT_FULL)) begin
        beat_cnt_q <= beat_cnt_q + CNT_ONE;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= STREAM;
            busy_q     <= 1'b1;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
          end
        end
        STREAM: begin
          if (rd_issue && (rd_cnt_q == CNT_LAST)) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (handshake && last_beat) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (inflight_q && !handshake) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (!inflight_q && handshake) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      inflight_q <= rd_issue;
      fifo_cnt_q <= fifo_cnt_d;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (handshake) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // When the FIFO is empty the returning RAM word is the head; it lands in
  // the head slot on the same edge, so signal_o holds across a stall.
  assign signal_o   = ((fifo_cnt_q == 2'd0) && inflight_q) ? mem_data_i : fifo_q[rd_ptr_q];
  assign ms_tvalid  = tvalid;
  assign ms_tlast   = tvalid && last_beat;
  assign mem_en_o   = rd_issue;
  assign mem_addr_o = rd_addr;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_result_streamer.sv
`default_nettype none
// Testbench for fft_result_streamer: frame-level model plus directed scenarios.
// Honours FFT_BITREV_READ_EN for the expected read order.
module tb_fft_result_streamer;

  localparam int N  = 8;
  localparam int W  = 50;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic          ms_tready = 1'b1;
  logic          busy_o, mem_en_o, ms_tvalid, ms_tlast, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_i = '0;
  logic [W-1:0]  signal_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit armed = 0;

  logic [W-1:0] ram [N];
  longint       lit_data [N];
  int           lit_addr [2];
  bit           rpat [6];

  always #5 clk_i = ~clk_i;

  fft_result_streamer #(.NUM_POINTS(N), .SIZE_OF_SIGNAL(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .ms_tvalid(ms_tvalid), .ms_tready(ms_tready), .ms_tlast(ms_tlast),
    .signal_o(signal_o), .done_o(done_o)
  );

  // Result RAM: synchronous read, garbage on the bus when not read.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_en_o) mem_data_i <= ram[mem_addr_o];
    else          mem_data_i <= W'({$urandom, $urandom});
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int addr_of(input int i);
    int r;
    r = i;
`ifdef FFT_BITREV_READ_EN
    r = 0;
    for (int b = 0; b < AW; b++) r = r * 2 + ((i >> b) & 1);
`endif
    return r;
  endfunction

  // Frame-level model: reads issued vs beats consumed.
  int  issued = 0, popped = 0;
  bit  m_busy = 0, m_done = 0;
  bit  prev_hold = 0;
  logic [W-1:0] prev_sig = '0;
  logic         prev_last = 1'b0;
  int  start_cyc = 0, cur_first_v = -1, cur_reads = 0, cur_tlast_n = 0, cur_tlast_cyc = -1;
  int  cur_addr [2];
  logic [W-1:0] cur_beats [$];
  logic [W-1:0] fr_beats [$];
  int  fr_first_v = 0, fr_first_abs = 0, fr_last = 0, fr_done = 0, fr_tlast_n = 0, done_abs = 0;

  always @(negedge clk_i) begin : mon
    bit was_busy, exp_v, exp_en;
    int outst;
    if (armed) begin
      outst    = issued - popped;
      exp_v    = outst > 0;
      exp_en   = m_busy && (issued < N) && (outst < 2);
      was_busy = m_busy;
      chk("tvalid", ms_tvalid, exp_v);
      chk("mem_en", mem_en_o, exp_en);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      if (exp_en) chk("mem_addr", mem_addr_o, addr_of(issued));
      if (exp_v) begin
        chk("data", signal_o, ram[addr_of(popped)]);
        chk("tlast", ms_tlast, (popped == N - 1));
      end else begin
        chk("tlast_idle", ms_tlast, 0);
      end
      if (prev_hold) begin
        chk("hold_valid", ms_tvalid, 1);
        chk("hold_data", signal_o, prev_sig);
        chk("hold_last", ms_tlast, prev_last);
      end

      if (ms_tvalid && cur_first_v < 0) cur_first_v = cyc;
      if (mem_en_o) begin
        if (cur_reads < 2) cur_addr[cur_reads] = int'(mem_addr_o);
        cur_reads++;
      end
      if (ms_tvalid && ms_tready) begin
        cur_beats.push_back(signal_o);
        if (ms_tlast) begin cur_tlast_n++; cur_tlast_cyc = cyc; end
      end
      if (done_o) begin
        fr_beats     = cur_beats;
        fr_first_v   = cur_first_v - start_cyc;
        fr_first_abs = cur_first_v;
        fr_last      = cur_tlast_cyc - start_cyc;
        fr_done      = cyc - start_cyc;
        fr_tlast_n   = cur_tlast_n;
        done_abs     = cyc;
      end
      prev_hold = ms_tvalid && !ms_tready;
      prev_sig  = signal_o;
      prev_last = ms_tlast;

      if (!reset_i) begin
        issued = 0; popped = 0; m_busy = 0; m_done = 0; prev_hold = 0;
      end else begin
        m_done = 0;
        if (exp_v && ms_tready) begin
          popped++;
          if (popped == N) begin m_busy = 0; m_done = 1; end
        end
        if (exp_en) issued++;
        if (start_i && !was_busy) begin
          m_busy = 1; issued = 0; popped = 0; start_cyc = cyc;
          cur_first_v = -1; cur_reads = 0; cur_tlast_n = 0; cur_tlast_cyc = -1;
          cur_beats.delete();
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit pat);
    bit seen;
    int k;
    seen = 0;
    k = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1;
      else if (pat) begin ms_tready = rpat[k % 6]; k++; end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic check_frame(input string tag, input bit timing);
    @(negedge clk_i); #1;
    chk($sformatf("%s_count", tag), fr_beats.size(), N);
    for (int i = 0; i < N; i++)
      if (i < fr_beats.size()) chk($sformatf("%s_beat%0d", tag, i), fr_beats[i], lit_data[i]);
    chk($sformatf("%s_tlast_n", tag), fr_tlast_n, 1);
    if (timing) begin
      chk($sformatf("%s_first_valid", tag), fr_first_v, 2);
      chk($sformatf("%s_tlast_cycle", tag), fr_last, 9);
      chk($sformatf("%s_done_cycle", tag), fr_done, 10);
    end
  endtask

  initial begin
    int d1;
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef FFT_BITREV_READ_EN
    for (int i = 0; i < N; i++) ram[i] = W'(i);
    lit_data = '{0, 4, 2, 6, 1, 5, 3, 7};
    lit_addr = '{0, 4};
`else
    for (int i = 0; i < N; i++) ram[i] = W'(100 + i);
    lit_data = '{100, 101, 102, 103, 104, 105, 106, 107};
    lit_addr = '{0, 1};
`endif

    idle(3);
    chk("rst_tvalid", ms_tvalid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_signal", signal_o, 0);
    chk("rst_tlast", ms_tlast, 0);
    chk("rst_done", done_o, 0);
    reset_i = 1'b1;
    armed   = 1;

    // Nominal frame
    idle(2); fr_beats.delete(); ms_tready = 1'b1;
    pulse_start();
    wait_done(40, 0);
    check_frame("nominal", 1);

    // Backpressure 1,0,0,1,0,1...
    idle(2); fr_beats.delete(); ms_tready = 1'b1;
    pulse_start();
    wait_done(100, 1);
    check_frame("backpressure", 0);
    ms_tready = 1'b1;

    // Stall from start
    idle(2); fr_beats.delete(); ms_tready = 1'b0;
    pulse_start();
    idle(9);
    chk("stall_reads", cur_reads, 2);
    chk("stall_addr0", cur_addr[0], lit_addr[0]);
    chk("stall_addr1", cur_addr[1], lit_addr[1]);
    ms_tready = 1'b1;
    wait_done(40, 0);
    check_frame("stall", 0);

    // Reset mid-frame after beat 3
    idle(2); ms_tready = 1'b1;
    pulse_start();
    for (int c = 0; c < 30 && cur_beats.size() < 3; c++) begin
      @(posedge clk_i); #1;
    end
    chk("mid_beats", cur_beats.size(), 3);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    chk("mid_rst_tvalid", ms_tvalid, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_tlast", ms_tlast, 0);
    chk("mid_rst_done", done_o, 0);
    idle(2); fr_beats.delete();
    pulse_start();
    wait_done(40, 0);
    check_frame("after_reset", 1);

    // Ignored restart mid-frame
    idle(2); fr_beats.delete();
    pulse_start();
    idle(3);
    pulse_start();
    wait_done(40, 0);
    check_frame("restart", 1);
    idle(3);
    chk("restart_not_queued", busy_o, 0);

    // Back-to-back: start in the done cycle
    idle(2); fr_beats.delete();
    pulse_start();
    wait_done(40, 0);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    d1 = done_abs;
    wait_done(40, 0);
    check_frame("b2b", 1);
    chk("b2b_gap", fr_first_abs - d1, 2);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
